// File: rtl/packet_parse_ctrl.sv
// packet_parse_ctrl
//   Top-level sequencer for the byte-stream packet parser. It hunts for a
//   preamble followed by a start-of-frame delimiter, then enables the header
//   parser and the payload/CRC parser in turn. Each stage is bounded by a
//   watchdog. Every packet ends with a one-cycle accept or drop pulse, and
//   running counts of accepted and dropped packets are kept.
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   data_in/data_valid  incoming byte stream (only examined in IDLE)
//   hdr_done/hdr_error  header parser verdict
//   pay_done            payload/CRC parser reached the full packet size
//   hdr_enable          enable to the header parser
//   pay_enable          enable to the payload/CRC parser
//   packet_valid        one-cycle pulse: packet accepted
//   packet_drop         one-cycle pulse: packet aborted
//   valid_packet_count  accepted packets, wraps modulo 2^CNT_W
//   drop_count          dropped packets, wraps modulo 2^CNT_W
//   state_out           IDLE=0, HEADER=1, PAYLOAD=2
module packet_parse_ctrl #(
    parameter int         PREAMBLE_LEN  = 7,
    parameter logic [7:0] PREAMBLE_BYTE = 8'h55,
    parameter logic [7:0] SFD_BYTE      = 8'hD5,
    parameter int         HDR_TIMEOUT   = 32,
    parameter int         PAY_TIMEOUT   = 64,
    parameter int         CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    input  logic             hdr_done,
    input  logic             hdr_error,
    input  logic             pay_done,
    output logic             hdr_enable,
    output logic             pay_enable,
    output logic             packet_valid,
    output logic             packet_drop,
    output logic [CNT_W-1:0] valid_packet_count,
    output logic [CNT_W-1:0] drop_count,
    output logic [1:0]       state_out
);

    localparam int PRE_W  = $clog2(PREAMBLE_LEN + 1);
    localparam int WD_MAX = (HDR_TIMEOUT > PAY_TIMEOUT) ? HDR_TIMEOUT : PAY_TIMEOUT;
    localparam int WD_W   = $clog2(WD_MAX);

    localparam logic [PRE_W-1:0] PRE_FULL = PRE_W'(PREAMBLE_LEN);
    localparam logic [WD_W-1:0]  HDR_LAST = WD_W'(HDR_TIMEOUT - 1);
    localparam logic [WD_W-1:0]  PAY_LAST = WD_W'(PAY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [PRE_W-1:0] pre_cnt_reg, pre_cnt_next;
    logic [WD_W-1:0]  wd_reg, wd_next;
    logic             accept, drop;

    logic             hdr_enable_reg, pay_enable_reg;
    logic             packet_valid_reg, packet_drop_reg;
    logic [CNT_W-1:0] valid_cnt_reg, drop_cnt_reg;

    always_comb begin
        state_next   = state_reg;
        pre_cnt_next = pre_cnt_reg;
        wd_next      = wd_reg + 1'b1;
        accept       = 1'b0;
        drop         = 1'b0;

        case (state_reg)
            IDLE: begin
                // Watchdog parked at zero so it starts clean on HEADER entry.
                wd_next = '0;
                if (data_valid) begin
                    if (data_in == SFD_BYTE && pre_cnt_reg == PRE_FULL) begin
                        state_next   = HEADER;
                        pre_cnt_next = '0;
                    end else if (data_in == PREAMBLE_BYTE) begin
                        if (pre_cnt_reg != PRE_FULL)
                            pre_cnt_next = pre_cnt_reg + 1'b1;
                    end else begin
                        // Any other byte, including an early SFD, restarts the hunt.
                        pre_cnt_next = '0;
                    end
                end
            end
            HEADER: begin
                if (hdr_error) begin
                    drop = 1'b1;
                end else if (hdr_done) begin
                    state_next = PAYLOAD;
                    wd_next    = '0;
                end else if (wd_reg == HDR_LAST) begin
                    drop = 1'b1;
                end
            end
            PAYLOAD: begin
                // pay_done is checked first so a coincident timeout still accepts.
                if (pay_done)
                    accept = 1'b1;
                else if (wd_reg == PAY_LAST)
                    drop = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (accept || drop) begin
            state_next   = IDLE;
            pre_cnt_next = '0;
            wd_next      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            pre_cnt_reg      <= '0;
            wd_reg           <= '0;
            hdr_enable_reg   <= 1'b0;
            pay_enable_reg   <= 1'b0;
            packet_valid_reg <= 1'b0;
            packet_drop_reg  <= 1'b0;
            valid_cnt_reg    <= '0;
            drop_cnt_reg     <= '0;
        end else begin
            state_reg        <= state_next;
            pre_cnt_reg      <= pre_cnt_next;
            wd_reg           <= wd_next;
            // Enables are decoded from the next state so they change on the
            // same edge as the state and never overlap.
            hdr_enable_reg   <= (state_next == HEADER);
            pay_enable_reg   <= (state_next == PAYLOAD);
            packet_valid_reg <= accept;
            packet_drop_reg  <= drop;
            if (accept)
                valid_cnt_reg <= valid_cnt_reg + 1'b1;
            if (drop)
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
    end

    assign hdr_enable         = hdr_enable_reg;
    assign pay_enable         = pay_enable_reg;
    assign packet_valid       = packet_valid_reg;
    assign packet_drop        = packet_drop_reg;
    assign valid_packet_count = valid_cnt_reg;
    assign drop_count         = drop_cnt_reg;
    assign state_out          = state_reg;

endmodule

// File: tb/tb_packet_parse_ctrl.sv
// Scoreboard bench for packet_parse_ctrl. Stimulus tasks push the expected
// enable run lengths and accept/drop events into queues; independent monitor
// processes sample on the falling edge and compare whenever the DUT presents
// an event or an enable window closes.
module tb_packet_parse_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       data_valid;
    logic       hdr_done;
    logic       hdr_error;
    logic       pay_done;
    logic       hdr_enable;
    logic       pay_enable;
    logic       packet_valid;
    logic       packet_drop;
    logic [3:0] valid_packet_count;
    logic [3:0] drop_count;
    logic [1:0] state_out;

    packet_parse_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .data_in            (data_in),
        .data_valid         (data_valid),
        .hdr_done           (hdr_done),
        .hdr_error          (hdr_error),
        .pay_done           (pay_done),
        .hdr_enable         (hdr_enable),
        .pay_enable         (pay_enable),
        .packet_valid       (packet_valid),
        .packet_drop        (packet_drop),
        .valid_packet_count (valid_packet_count),
        .drop_count         (drop_count),
        .state_out          (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_valid;
        logic [3:0] vc;
        logic [3:0] dc;
    } ev_t;

    ev_t ev_q[$];
    int  hdr_q[$];
    int  pay_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0] exp_v = 4'd0;
    logic [3:0] exp_d = 4'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    int  hdr_run   = 0;
    int  pay_run   = 0;
    bit  prev_valid = 0;
    bit  prev_drop  = 0;
    ev_t cur_ev;
    int  cur_len;

    always @(negedge clk) begin
        if (packet_valid || packet_drop) begin
            check("pulse_one_cycle", {31'd0, (packet_valid && prev_valid) || (packet_drop && prev_drop)}, 32'd0);
            if (ev_q.size() == 0) begin
                check("unexpected_event", {30'd0, packet_valid, packet_drop}, 32'd0);
            end else begin
                cur_ev = ev_q.pop_front();
                check("event_kind", {30'd0, packet_valid, packet_drop},
                      cur_ev.is_valid ? 32'd2 : 32'd1);
                check("valid_count", {28'd0, valid_packet_count}, {28'd0, cur_ev.vc});
                check("drop_count", {28'd0, drop_count}, {28'd0, cur_ev.dc});
                $display("event %s vcount=%0d dcount=%0d", packet_valid ? "accept" : "drop",
                         valid_packet_count, drop_count);
            end
        end
        prev_valid = packet_valid;
        prev_drop  = packet_drop;
    end

    always @(negedge clk) begin
        if (hdr_enable || pay_enable)
            check("enables_exclusive", {31'd0, hdr_enable && pay_enable}, 32'd0);
        if (hdr_enable) begin
            hdr_run++;
        end else if (hdr_run > 0) begin
            if (hdr_q.size() == 0) begin
                check("unexpected_hdr_window", hdr_run, 32'd0);
            end else begin
                cur_len = hdr_q.pop_front();
                check("hdr_enable_len", hdr_run, cur_len);
                $display("hdr_enable window %0d cycles", hdr_run);
            end
            hdr_run = 0;
        end
        if (pay_enable) begin
            pay_run++;
        end else if (pay_run > 0) begin
            if (pay_q.size() == 0) begin
                check("unexpected_pay_window", pay_run, 32'd0);
            end else begin
                cur_len = pay_q.pop_front();
                check("pay_enable_len", pay_run, cur_len);
                $display("pay_enable window %0d cycles", pay_run);
            end
            pay_run = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        data_in    = 8'h00;
    endtask

    task automatic preamble(input int n);
        repeat (n) send_byte(8'h55);
    endtask

    task automatic start_frame();
        preamble(7);
        send_byte(8'hD5);
    endtask

    // hdr_done sampled hd edges after the SFD edge.
    task automatic header_ok(input int hd);
        hdr_q.push_back(hd);
        idle(hd - 1);
        hdr_done = 1'b1;
        tick();
        hdr_done = 1'b0;
    endtask

    task automatic payload_ok(input int pd);
        ev_t e;
        pay_q.push_back(pd);
        exp_v = exp_v + 4'd1;
        e.is_valid = 1'b1; e.vc = exp_v; e.dc = exp_d;
        ev_q.push_back(e);
        idle(pd - 1);
        pay_done = 1'b1;
        tick();
        pay_done = 1'b0;
    endtask

    task automatic expect_drop();
        ev_t e;
        exp_d = exp_d + 4'd1;
        e.is_valid = 1'b0; e.vc = exp_v; e.dc = exp_d;
        ev_q.push_back(e);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n      = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        hdr_done   = 1'b0;
        hdr_error  = 1'b0;
        pay_done   = 1'b0;
        idle(3);
        check("reset_state", {30'd0, state_out}, 32'd0);
        check("reset_enables", {30'd0, hdr_enable, pay_enable}, 32'd0);
        check("reset_pulses", {30'd0, packet_valid, packet_drop}, 32'd0);
        check("reset_counts", {24'd0, valid_packet_count, drop_count}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Nominal packet
        start_frame();
        check("nominal_state_header", {30'd0, state_out}, 32'd1);
        header_ok(3);
        check("nominal_state_payload", {30'd0, state_out}, 32'd2);
        payload_ok(50);
        check("nominal_state_idle", {30'd0, state_out}, 32'd0);
        idle(3);

        // Short preamble: 6 x 55 then SFD must not start a packet
        preamble(6);
        send_byte(8'hD5);
        idle(2);
        check("short_pre_state", {30'd0, state_out}, 32'd0);
        check("short_pre_enable", {31'd0, hdr_enable}, 32'd0);

        // Broken preamble then a full one
        preamble(3);
        send_byte(8'h00);
        preamble(7);
        check("break_before_sfd", {30'd0, state_out}, 32'd0);
        send_byte(8'hD5);
        check("break_after_sfd", {30'd0, state_out}, 32'd1);
        header_ok(3);
        payload_ok(5);
        idle(2);

        // data_valid gaps inside the preamble hold the count
        preamble(4);
        data_in = 8'h00;
        idle(3);
        preamble(3);
        send_byte(8'hD5);
        check("gap_after_sfd", {30'd0, state_out}, 32'd1);
        header_ok(2);
        payload_ok(4);
        idle(2);

        // Header error together with hdr_done: error wins
        start_frame();
        hdr_q.push_back(2);
        expect_drop();
        idle(1);
        hdr_error = 1'b1;
        hdr_done  = 1'b1;
        tick();
        hdr_error = 1'b0;
        hdr_done  = 1'b0;
        check("hdr_err_state", {30'd0, state_out}, 32'd0);
        idle(2);

        // Header timeout: drop 32 cycles after entry
        start_frame();
        hdr_q.push_back(32);
        expect_drop();
        idle(31);
        check("hdr_wd_still_header", {30'd0, state_out}, 32'd1);
        idle(1);
        check("hdr_wd_dropped", {30'd0, state_out}, 32'd0);
        idle(2);

        // pay_done coincident with the payload timeout: accepted
        start_frame();
        header_ok(2);
        payload_ok(64);
        idle(2);

        // Payload timeout without pay_done
        start_frame();
        header_ok(2);
        pay_q.push_back(64);
        expect_drop();
        idle(64);
        check("pay_wd_dropped", {30'd0, state_out}, 32'd0);
        idle(2);

        // 17 back-to-back good packets, counter wraps
        for (int i = 0; i < 17; i++) begin
            start_frame();
            header_ok(2);
            payload_ok(3);
        end
        idle(2);
        check("wrap_valid_count", {28'd0, valid_packet_count}, 32'd5);

        // Asynchronous reset in the middle of PAYLOAD
        start_frame();
        header_ok(2);
        pay_q.push_back(10);
        idle(10);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_pay_enable", {31'd0, pay_enable}, 32'd0);
        check("async_rst_state", {30'd0, state_out}, 32'd0);
        check("async_rst_counts", {24'd0, valid_packet_count, drop_count}, 32'd0);
        exp_v = 4'd0;
        exp_d = 4'd0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        start_frame();
        header_ok(3);
        payload_ok(4);
        idle(4);
        check("post_rst_valid_count", {28'd0, valid_packet_count}, 32'd1);

        check("ev_queue_drained", ev_q.size(), 32'd0);
        check("hdr_queue_drained", hdr_q.size(), 32'd0);
        check("pay_queue_drained", pay_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
